timer_access_arbiter: RTL

//  Shares one 16-bit interval-timer register slave (6 regs, addr 0-5) among NUM_REQ cores.

---
 rtl/timer_arb_pkg.sv | 22 ++
 rtl/timer_arb_rr_arbiter.sv | 40 ++++
 rtl/timer_access_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/timer_arb_pkg.sv
// ----------------------------------------------------------------------------
// timer_arb_pkg
// Shared types and constants for the timer access arbiter.
//   state_t      : sequencer states (IDLE -> ISSUE -> RESP -> IDLE)
//   TMR_*        : register addresses of the 16-bit interval-timer slave
// ----------------------------------------------------------------------------
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int TMR_STATUS  = 0;
    localparam int TMR_CONTROL = 1;
    localparam int TMR_PERIODL = 2;
    localparam int TMR_PERIODH = 3;
    localparam int TMR_SNAPL   = 4;
    localparam int TMR_SNAPH   = 5;

endpackage

// File: rtl/timer_arb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Search starts at last_grant+1 (mod NUM_REQ)
// and wraps, so the most recent winner has lowest priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    index of the previous winner
//   grant      out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx  out IDX_W    index of the winner (last_grant when no request)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;

    // Outer loop walks priority order; inner loop keeps every index constant
    // so the selection unrolls into a flat compare tree.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && ((int'(last_grant) + off) % NUM_REQ == i)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/timer_access_arbiter.sv
// ----------------------------------------------------------------------------
// timer_access_arbiter
// Shares one 16-bit interval-timer register slave among NUM_REQ cores.
// Requests are arbitrated round-robin and serialised into the slave, one
// access every three cycles (IDLE -> ISSUE -> RESP). The slave has no
// waitrequest and returns registered readdata one cycle after chipselect;
// this block provides waitrequest upstream.
//
// Optional feature (macro TIMER_ARB_LOCK_EN): a granted write to period_l
// locks the slave to that requester until it writes period_h or until
// LOCK_TIMEOUT cycles elapse, keeping 32-bit period writes atomic.
// Without the macro, lock_active is tied 0.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   req_chipselect      per-requester access request
//   req_write_n         per-requester 0=write 1=read
//   req_address         packed, requester i at [i*ADDR_W +: ADDR_W]
//   req_writedata       packed, requester i at [i*DATA_W +: DATA_W]
//   req_waitrequest     per-requester stall, low one cycle on completion
//   req_readdata        shared read bus, valid with own waitrequest low
//   tmr_*               timer slave interface
//   lock_active         period-write lock held
// ----------------------------------------------------------------------------
module timer_access_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 16,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_chipselect,
    input  logic [NUM_REQ-1:0]        req_write_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic                      tmr_chipselect,
    output logic                      tmr_write_n,
    output logic [ADDR_W-1:0]         tmr_address,
    output logic [DATA_W-1:0]         tmr_writedata,
    input  logic [DATA_W-1:0]         tmr_readdata,
    output logic                      lock_active
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1) begin : g_bad_param
        $error("timer_access_arbiter: NUM_REQ must be 2..8 and LOCK_TIMEOUT >= 1");
    end

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [DATA_W-1:0]  rdata_hold;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               win_write_n;
    logic [ADDR_W-1:0]  win_address;
    logic [DATA_W-1:0]  win_writedata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (arb_req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    // One-hot AND-OR select of the winner's command fields.
    always_comb begin
        win_write_n   = 1'b1;
        win_address   = '0;
        win_writedata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_write_n   = req_write_n[i];
                win_address   = req_address[i*ADDR_W +: ADDR_W];
                win_writedata = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef TIMER_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    logic               lock_held;
    logic [IDX_W-1:0]   lock_owner;
    logic [CNT_W-1:0]   lock_cnt;
    logic               grant_now;

    assign grant_now   = (state == IDLE) && (|grant);
    // While locked, only the owner is visible to the arbiter.
    assign arb_req     = lock_held ? (req_chipselect & (NUM_REQ'(1) << lock_owner))
                                   : req_chipselect;
    assign lock_active = lock_held;

    // A period_l write (re)arms the lock; the owner's period_h write or the
    // timeout releases it. last_grant already equals the owner, so rotation
    // resumes from owner+1 automatically.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_held  <= 1'b0;
            lock_owner <= '0;
            lock_cnt   <= '0;
        end else if (grant_now && !win_write_n && win_address == ADDR_W'(TMR_PERIODL)) begin
            lock_held  <= 1'b1;
            lock_owner <= grant_idx;
            lock_cnt   <= '0;
        end else if (grant_now && lock_held && !win_write_n &&
                     win_address == ADDR_W'(TMR_PERIODH)) begin
            lock_held <= 1'b0;
        end else if (lock_held) begin
            if (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                lock_held <= 1'b0;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end
`else
    assign arb_req     = req_chipselect;
    assign lock_active = 1'b0;
`endif

    // During RESP of a read the slave's registered data is passed straight
    // through so it lines up with the waitrequest-low cycle; otherwise the
    // last read value is held.
    assign req_readdata = (state == RESP && tmr_write_n) ? tmr_readdata : rdata_hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            req_waitrequest <= '1;
            rdata_hold      <= '0;
            tmr_chipselect  <= 1'b0;
            tmr_write_n     <= 1'b1;
            tmr_address     <= '0;
            tmr_writedata   <= '0;
            last_grant      <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= win_write_n;
                        tmr_address    <= win_address;
                        tmr_writedata  <= win_writedata;
                        last_grant     <= grant_idx;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmr_chipselect  <= 1'b0;
                    req_waitrequest <= ~(NUM_REQ'(1) << last_grant);
                    state           <= RESP;
                end
                RESP: begin
                    req_waitrequest <= '1;
                    if (tmr_write_n) begin
                        rdata_hold <= tmr_readdata;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
